subpel_row_scheduler: RTL and testbench
=======================================

Name: subpel_row_scheduler

Overview:
- Sequences the subpixel interpolation datapath for one 8x8 output block.
- Issues 15 consecutive row reads (8-tap FIR needs 8+7 rows) to the image row memory and forwards each returned 120-bit row (15 pixels x 8 bits) to the datapath with a load strobe.
- Flags which datapath outputs are valid.
- Gives the block-level controller a start/busy/done handshake.

Parameters:
- ADDR_W, 15: row address width; the row memory holds 2^ADDR_W rows.
- ROW_W, 120: row width in bits (15 pixels x 8 bits).
- BLK_ROWS, 15: rows fetched per block.
- TAPS, 8: filter taps; the first valid output follows load TAPS-1.
- MEM_LAT, 1: memory read latency in cycles (fixed, 1..4).
- DP_LAT, 2: cycles from dp_load to the corresponding datapath output (1..4).

Ports:
- clk in 1: clock.
- rst in 1: synchronous reset, active-high.
- start in 1: start one block; sampled only in IDLE.
- base_row in ADDR_W: first row address; captured when start is accepted.
- hold in 1: while high, no new memory reads are issued.
- busy out 1: a block is in progress.
- done out 1: one-cycle completion pulse.
- start_err out 1: one-cycle pulse when start is seen while not IDLE.
- mem_rd out 1: memory read strobe.
- mem_addr out ADDR_W: memory read address.
- mem_data in ROW_W: read data, valid MEM_LAT cycles after mem_rd.
- dp_clear out 1: flush the datapath row window.
- dp_load out 1: shift dp_row into the datapath.
- dp_row out ROW_W: row presented to the datapath.
- out_valid out 1: datapath output this cycle is valid.
- out_row_idx out 3: output row index 0..7 within the block.

Behaviour:
- Reset: every output is 0 and the state is IDLE. All counters and the MEM_LAT/DP_LAT delay lines are cleared. A reset mid-block abandons the block: no further dp_load, out_valid or done, and rows still in flight are discarded.
- State IDLE:
  - start=1 at edge N captures base_row, enters FETCH at N+1 and sets busy=1 from N+1.
  - start=1 in any other state is ignored and pulses start_err for one cycle.
- State FETCH:
  - dp_clear=1 on the first FETCH cycle only.
  - Each cycle with hold=0 and issue_cnt<BLK_ROWS: mem_rd=1, mem_addr=base_row+issue_cnt (modulo 2^ADDR_W, wraps silently), issue_cnt increments.
  - hold=1 gives mem_rd=0 and freezes issue_cnt. Reads already in flight still complete and load.
  - hold may toggle any cycle, including the FETCH entry cycle (dp_clear still asserts).
  - The state moves to DRAIN after the BLK_ROWS-th read is issued.
- Load path:
  - dp_load is mem_rd delayed by exactly MEM_LAT cycles.
  - dp_row = mem_data, combinational passthrough, qualified by dp_load.
  - load_cnt counts dp_load pulses from 0.
- Output path:
  - For every load with load_cnt >= TAPS-1, out_valid=1 exactly DP_LAT cycles later.
  - out_row_idx = load_cnt-(TAPS-1) at load time, delayed alongside out_valid.
  - Exactly BLK_ROWS-TAPS+1 = 8 out_valid pulses per block, indices 0..7 in order.
  - Gaps in out_valid mirror hold gaps.
- State DRAIN: waits for the out_valid with index 7. The next cycle goes to DONE.
- State DONE: done=1 for one cycle with busy=1, then IDLE with busy=0. The earliest new start is accepted in the IDLE cycle after DONE.
- Nominal timing (MEM_LAT=1, DP_LAT=2, no hold), start at cycle 0:
  - mem_rd cycles 1..15.
  - dp_load cycles 2..16.
  - out_valid cycles 11..18.
  - done at cycle 19; busy cycles 1..19.
- Counters are 4 bits wide and saturate-checked: issue_cnt never exceeds BLK_ROWS.

Test Plan:
- Nominal block: start=1 with base_row=0x0010 at cycle 0, hold=0 → mem_addr 0x0010..0x001E on cycles 1..15; 15 dp_load pulses; 8 out_valid on cycles 11..18 with out_row_idx 0..7; done at 19 only.
- Address wrap: base_row=0x7FF8 → addresses 0x7FF8..0x7FFF then 0x0000..0x0006; everything else identical to the nominal case.
- Hold: hold=1 during cycles 5..7 → mem_rd gap on cycles 5..7, 15 reads total, last read at cycle 18; out_valid ends at cycle 21 and done at 22; indices remain contiguous 0..7.
- Start while busy: a second start at cycle 6 → start_err pulse, no change to addresses or counts; a start at cycle 20 (IDLE) is accepted and dp_clear asserts at cycle 21.
- Reset mid-block: rst=1 at cycle 9 → from cycle 10 busy=0, dp_load=0, out_valid=0, no done; a new start then behaves exactly like the nominal case.
- Parameter sweep: MEM_LAT=3, DP_LAT=1 → dp_load cycles 4..18, out_valid cycles 12..19, done at 20.

Source files
------------

// File: rtl/subpel_row_if.sv
// subpel_row_if: bundles the control handshake, row-memory read port and
// datapath load port of the subpixel row scheduler.
//   master : the scheduler (drives busy/done/start_err, mem_rd/mem_addr,
//            dp_clear/dp_load/dp_row, out_valid/out_row_idx)
//   slave  : the environment (drives start/base_row/hold and mem_data)
interface subpel_row_if #(
    parameter int ADDR_W = 15,
    parameter int ROW_W  = 120
);
    logic              start;
    logic [ADDR_W-1:0] base_row;
    logic              hold;
    logic              busy;
    logic              done;
    logic              start_err;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [ROW_W-1:0]  mem_data;
    logic              dp_clear;
    logic              dp_load;
    logic [ROW_W-1:0]  dp_row;
    logic              out_valid;
    logic [2:0]        out_row_idx;

    modport master (
        input  start, base_row, hold, mem_data,
        output busy, done, start_err, mem_rd, mem_addr,
               dp_clear, dp_load, dp_row, out_valid, out_row_idx
    );

    modport slave (
        output start, base_row, hold, mem_data,
        input  busy, done, start_err, mem_rd, mem_addr,
               dp_clear, dp_load, dp_row, out_valid, out_row_idx
    );
endinterface

// File: rtl/subpel_row_scheduler.sv
// subpel_row_scheduler: sequences one 8x8 subpixel interpolation block.
// Issues BLK_ROWS consecutive row reads starting at base_row, forwards each
// returned row to the datapath with dp_load, and flags the datapath outputs
// that are valid once the TAPS-row filter window is full.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : subpel_row_if.master
//              start/base_row/busy/done/start_err : block handshake
//              hold                               : stall new reads
//              mem_rd/mem_addr/mem_data           : row memory read port
//              dp_clear/dp_load/dp_row            : datapath row feed
//              out_valid/out_row_idx              : datapath output qualifier
module subpel_row_scheduler #(
    parameter int ADDR_W   = 15,
    parameter int ROW_W    = 120,
    parameter int BLK_ROWS = 15,
    parameter int TAPS     = 8,
    parameter int MEM_LAT  = 1,
    parameter int DP_LAT   = 2
) (
    input logic          clk,
    input logic          rst,
    subpel_row_if.master bus
);

    localparam logic [3:0] ISSUE_MAX  = 4'(BLK_ROWS);
    localparam logic [3:0] LAST_ISSUE = 4'(BLK_ROWS - 1);
    localparam logic [3:0] FIRST_OUT  = 4'(TAPS - 1);
    localparam logic [2:0] LAST_IDX   = 3'(BLK_ROWS - TAPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        issue_cnt;
    logic [3:0]        load_cnt;
    logic              clear_q;
    logic [MEM_LAT-1:0] rd_pipe;
    logic [DP_LAT-1:0]  ov_pipe;
    logic [2:0]         idx_pipe [DP_LAT];

    logic       accept;
    logic       issue;
    logic       ov_in;
    logic [2:0] idx_in;

    assign accept = (state == S_IDLE) && bus.start;
    // issue_cnt never passes ISSUE_MAX because issuing stops there.
    assign issue  = (state == S_FETCH) && !bus.hold && (issue_cnt < ISSUE_MAX);
    // The first TAPS-1 loads only prime the filter window.
    assign ov_in  = bus.dp_load && (load_cnt >= FIRST_OUT);
    assign idx_in = 3'(load_cnt - FIRST_OUT);

    // NOTE: every variable gets a default at the top of always_comb so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_FETCH;
            S_FETCH: if (issue && (issue_cnt == LAST_ISSUE)) state_nx = S_DRAIN;
            S_DRAIN: if (bus.out_valid && (bus.out_row_idx == LAST_IDX)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            base_q    <= '0;
            issue_cnt <= '0;
            load_cnt  <= '0;
            clear_q   <= 1'b0;
            // NOTE: the latency delay lines are small flop chains, not RAM, and
            // are reset so rows in flight from an abandoned block never load.
            rd_pipe   <= '0;
            ov_pipe   <= '0;
            for (int i = 0; i < DP_LAT; i++) idx_pipe[i] <= '0;
        end else begin
            state   <= state_nx;
            clear_q <= accept;

            if (accept) begin
                base_q    <= bus.base_row;
                issue_cnt <= '0;
                load_cnt  <= '0;
            end else begin
                if (issue)       issue_cnt <= issue_cnt + 4'd1;
                if (bus.dp_load) load_cnt  <= load_cnt + 4'd1;
            end

            // Read strobe delayed by the memory latency becomes dp_load.
            rd_pipe[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

            // Output qualifier and row index travel together through the
            // datapath latency.
            ov_pipe[0]  <= ov_in;
            idx_pipe[0] <= idx_in;
            for (int i = 1; i < DP_LAT; i++) begin
                ov_pipe[i]  <= ov_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.start_err   = bus.start && (state != S_IDLE);
    assign bus.mem_rd      = issue;
    // Address wraps modulo 2^ADDR_W by plain truncating addition.
    assign bus.mem_addr    = issue ? (base_q + ADDR_W'(issue_cnt)) : '0;
    assign bus.dp_clear    = clear_q;
    assign bus.dp_load     = rd_pipe[MEM_LAT-1];
    assign bus.dp_row      = bus.dp_load ? bus.mem_data : {ROW_W{1'b0}};
    assign bus.out_valid   = ov_pipe[DP_LAT-1];
    assign bus.out_row_idx = idx_pipe[DP_LAT-1];

endmodule

// File: tb/tb_subpel_row_scheduler.sv
// tb_subpel_row_scheduler: drives two schedulers (MEM_LAT=1/DP_LAT=2 and
// MEM_LAT=3/DP_LAT=1) with the same start/base/hold/reset stimulus and
// compares every output each cycle against an expected timeline built from
// the block rules: reads fill non-hold cycles, loads follow after MEM_LAT,
// outputs follow loads with index >= TAPS-1 after DP_LAT, done one cycle after
// the last output. Cycle k means the values present at rising edge k.
module tb_subpel_row_scheduler;

    localparam int N   = 640;
    localparam int END = 560;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subpel_row_if #(.ADDR_W(15), .ROW_W(120)) if_a ();
    subpel_row_if #(.ADDR_W(15), .ROW_W(120)) if_b ();

    subpel_row_scheduler dut_a (.clk(clk), .rst(rst), .bus(if_a.master));
    subpel_row_scheduler #(.MEM_LAT(3), .DP_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.master));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus timeline
    logic        st_v   [N];
    logic        rst_v  [N];
    logic        hold_v [N];
    logic [14:0] base_v [N];

    // expected timeline per DUT
    logic        e_rd   [2][N];
    logic        e_ld   [2][N];
    logic        e_ov   [2][N];
    logic        e_busy [2][N];
    logic        e_done [2][N];
    logic        e_clr  [2][N];
    logic        e_serr [2][N];
    logic        skip   [2][N];
    logic [14:0] e_addr [2][N];
    logic [14:0] e_laddr[2][N];
    logic [2:0]  e_idx  [2][N];

    // observed reads, used only by the memory responder
    logic        o_rd   [2][N];
    logic [14:0] o_addr [2][N];

    int done_q0[$];
    int done_q1[$];

    task automatic check(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut=%0d cyc=%0d got=%0h exp=%0h", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic clr_exp(input int d, input int c);
        e_rd[d][c] = 0; e_ld[d][c] = 0; e_ov[d][c] = 0; e_busy[d][c] = 0;
        e_done[d][c] = 0; e_clr[d][c] = 0; e_serr[d][c] = 0;
        e_addr[d][c] = '0; e_laddr[d][c] = '0; e_idx[d][c] = '0;
    endtask

    // Builds the expected timeline of one DUT from the stimulus arrays.
    task automatic plan(input int d, input int ml, input int dl);
        int busy_end;
        int k;
        int cnt;
        int last;
        for (int c = 0; c < N; c++) begin
            clr_exp(d, c);
            skip[d][c] = 0;
        end
        busy_end = -1;
        for (int c = 0; c < END; c++) begin
            if (rst_v[c]) begin
                skip[d][c] = 1;
                for (int j = c + 1; j < N; j++) clr_exp(d, j);
                busy_end = c;
            end else if (st_v[c]) begin
                if (c > busy_end) begin
                    cnt  = 0;
                    last = c;
                    k    = c + 1;
                    e_clr[d][k] = 1;
                    while (cnt < 15) begin
                        if (!hold_v[k]) begin
                            e_rd[d][k]         = 1;
                            e_addr[d][k]       = base_v[c] + 15'(cnt);
                            e_ld[d][k+ml]      = 1;
                            e_laddr[d][k+ml]   = base_v[c] + 15'(cnt);
                            if (cnt >= 7) begin
                                e_ov[d][k+ml+dl]  = 1;
                                e_idx[d][k+ml+dl] = 3'(cnt - 7);
                                last = k + ml + dl;
                            end
                            cnt++;
                        end
                        k++;
                    end
                    e_done[d][last+1] = 1;
                    for (int j = c + 1; j <= last + 1; j++) e_busy[d][j] = 1;
                    busy_end = last + 1;
                end else begin
                    e_serr[d][c] = 1;
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input logic busy, input logic done, input logic serr,
                             input logic rd, input logic [14:0] addr, input logic clr,
                             input logic ld, input logic [119:0] row, input logic ov,
                             input logic [2:0] idx);
        if (!skip[d][cyc]) begin
            check("busy",      d, 128'(busy), 128'(e_busy[d][cyc]));
            check("done",      d, 128'(done), 128'(e_done[d][cyc]));
            check("start_err", d, 128'(serr), 128'(e_serr[d][cyc]));
            check("mem_rd",    d, 128'(rd),   128'(e_rd[d][cyc]));
            check("dp_clear",  d, 128'(clr),  128'(e_clr[d][cyc]));
            check("dp_load",   d, 128'(ld),   128'(e_ld[d][cyc]));
            check("out_valid", d, 128'(ov),   128'(e_ov[d][cyc]));
            if (e_rd[d][cyc]) check("mem_addr", d, 128'(addr), 128'(e_addr[d][cyc]));
            if (e_ld[d][cyc]) check("dp_row",   d, 128'(row),  128'({8{e_laddr[d][cyc]}}));
            if (e_ov[d][cyc]) check("out_row_idx", d, 128'(idx), 128'(e_idx[d][cyc]));
        end
    endtask

    initial begin
        logic [127:0] rnd;
        int s;

        for (int c = 0; c < N; c++) begin
            st_v[c] = 0; rst_v[c] = 0; hold_v[c] = 0; base_v[c] = '0;
            o_rd[0][c] = 0; o_rd[1][c] = 0; o_addr[0][c] = '0; o_addr[1][c] = '0;
        end

        // power-on reset
        rst_v[0] = 1; rst_v[1] = 1;
        // nominal block
        st_v[5] = 1;  base_v[5] = 15'h0010;
        // address wrap
        st_v[30] = 1; base_v[30] = 15'h7FF8;
        // hold on relative cycles 5..7
        st_v[60] = 1; base_v[60] = 15'h1234;
        hold_v[65] = 1; hold_v[66] = 1; hold_v[67] = 1;
        // start while busy, then start right after DONE
        st_v[90] = 1;  base_v[90] = 15'h0100;
        st_v[96] = 1;  base_v[96] = 15'h5555;
        st_v[110] = 1; base_v[110] = 15'h0200;
        // reset mid-block then a fresh block
        st_v[140] = 1; base_v[140] = 15'h0300;
        rst_v[149] = 1;
        st_v[155] = 1; base_v[155] = 15'($urandom_range(0, 32767));
        // randomized blocks with random holds and a stray start
        for (int i = 0; i < 6; i++) begin
            s = 180 + 60 * i;
            st_v[s] = 1;
            base_v[s] = 15'($urandom_range(0, 32767));
            for (int j = s + 1; j <= s + 35; j++) hold_v[j] = ($urandom_range(0, 3) == 0);
            if (i == 0) hold_v[s+1] = 1;
            st_v[s+10] = 1;
            base_v[s+10] = 15'($urandom_range(0, 32767));
        end

        plan(0, 1, 2);
        plan(1, 3, 1);

        for (cyc = 0; cyc < END; cyc++) begin
            @(negedge clk);
            rst           = rst_v[cyc];
            if_a.start    = st_v[cyc];
            if_b.start    = st_v[cyc];
            if_a.base_row = base_v[cyc];
            if_b.base_row = base_v[cyc];
            if_a.hold     = hold_v[cyc];
            if_b.hold     = hold_v[cyc];
            rnd = {$urandom, $urandom, $urandom, $urandom};
            if (cyc >= 1 && o_rd[0][cyc-1] === 1'b1) if_a.mem_data = {8{o_addr[0][cyc-1]}};
            else                                     if_a.mem_data = rnd[119:0];
            rnd = {$urandom, $urandom, $urandom, $urandom};
            if (cyc >= 3 && o_rd[1][cyc-3] === 1'b1) if_b.mem_data = {8{o_addr[1][cyc-3]}};
            else                                     if_b.mem_data = rnd[119:0];
            #1;
            check_dut(0, if_a.busy, if_a.done, if_a.start_err, if_a.mem_rd, if_a.mem_addr,
                      if_a.dp_clear, if_a.dp_load, if_a.dp_row, if_a.out_valid, if_a.out_row_idx);
            check_dut(1, if_b.busy, if_b.done, if_b.start_err, if_b.mem_rd, if_b.mem_addr,
                      if_b.dp_clear, if_b.dp_load, if_b.dp_row, if_b.out_valid, if_b.out_row_idx);
            o_rd[0][cyc]   = if_a.mem_rd;
            o_addr[0][cyc] = if_a.mem_addr;
            o_rd[1][cyc]   = if_b.mem_rd;
            o_addr[1][cyc] = if_b.mem_addr;
            if (!rst_v[cyc] && if_a.done === 1'b1) done_q0.push_back(cyc);
            if (!rst_v[cyc] && if_b.done === 1'b1) done_q1.push_back(cyc);
        end

        // Completion cycles of the directed blocks, from the nominal timing
        // rules: nominal/wrap done 19 (sweep 20) after start, hold done 22 (23).
        check("done_count_a", 0, 128'(done_q0.size()), 128'(12));
        check("done_count_b", 1, 128'(done_q1.size()), 128'(11));
        check("done_nom_a",   0, 128'(done_q0[0]), 128'(5 + 19));
        check("done_wrap_a",  0, 128'(done_q0[1]), 128'(30 + 19));
        check("done_hold_a",  0, 128'(done_q0[2]), 128'(60 + 22));
        check("done_nom_b",   1, 128'(done_q1[0]), 128'(5 + 20));
        check("done_wrap_b",  1, 128'(done_q1[1]), 128'(30 + 20));
        check("done_hold_b",  1, 128'(done_q1[2]), 128'(60 + 23));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
